ov5640_dvp_tx: RTL and testbench

Generates an OV5640-style DVP stream (`ov5640_vsync`, `ov5640_href`, 8-bit `ov5640_data`) from 16-bit pixels read out of a first-word-fall-through FIFO. It is the transmitter side of the camera capture path. Its uses are:
- camera emulation in simulation;
- loopback into the DVP capture block on the board, without a sensor.

Each pixel goes out high byte first, then low byte. A capture block that concatenates {first byte, second byte} therefore rebuilds the original word.

---
 rtl/ov5640_dvp_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ov5640_dvp_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: streams 16-bit FWFT FIFO pixels as H/L bytes with vsync/href timing.
// Optional colour-bar source is compiled in when OV5640_TX_PATTERN_EN is defined.
module ov5640_dvp_tx #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 32,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_CYC   = 64,
   parameter int V_BACK_CYC  = 128,
   parameter int V_FRONT_CYC = 128
) (
   input  logic        ov5640_pclk,
   input  logic        sys_rst_n,
   input  logic        frame_en,
   input  logic [15:0] fifo_rd_data,
   input  logic        fifo_empty,
`ifdef OV5640_TX_PATTERN_EN
   input  logic        pattern_sel,
`endif
   output logic        fifo_rd_en,
   output logic        ov5640_vsync,
   output logic        ov5640_href,
   output logic [7:0]  ov5640_data,
   output logic        frame_start,
   output logic        underflow
);

   localparam int PIX_W  = $clog2(2 * H_ACTIVE);
   localparam int LINE_W = $clog2(V_ACTIVE + 1);

   localparam logic [15:0]       VSYNC_LAST  = 16'(VSYNC_CYC - 1);
   localparam logic [15:0]       VBP_LAST    = 16'(V_BACK_CYC - 1);
   localparam logic [15:0]       HBLANK_LAST = 16'(H_BLANK - 1);
   localparam logic [15:0]       VFP_LAST    = 16'(V_FRONT_CYC - 1);
   localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(2 * H_ACTIVE - 1);
   localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(V_ACTIVE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBP,
      S_ACTIVE,
      S_HBLANK,
      S_VFP
   } state_t;

   state_t            state;
   state_t            nxt_state;
   logic [15:0]       phase_cnt;
   logic [15:0]       nxt_phase;
   logic [PIX_W-1:0]  pix_cnt;
   logic [PIX_W-1:0]  nxt_pix;
   logic [LINE_W-1:0] line_cnt;
   logic [LINE_W-1:0] nxt_line;

   logic              load_h;
   logic              load_l;
   logic              frame_begin;
   logic              use_pattern;
   logic              vsync_nxt;
   logic              href_nxt;
   logic              underflow_nxt;
   logic [7:0]        data_nxt;
   logic [15:0]       src_pixel;
   logic [15:0]       fifo_pixel;
   logic [15:0]       pixel_reg;
   logic [15:0]       pixel_nxt;

   // State and counters describe the cycle currently on the bus; outputs are
   // registered from the next-cycle values so they line up with the state.
   always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= S_IDLE;
         phase_cnt <= '0;
         pix_cnt   <= '0;
         line_cnt  <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state     <= nxt_state;
         phase_cnt <= nxt_phase;
         pix_cnt   <= nxt_pix;
         line_cnt  <= nxt_line;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      nxt_state = state;
      nxt_phase = phase_cnt;
      nxt_pix   = pix_cnt;
      nxt_line  = line_cnt;
      case (state)
         S_IDLE: begin
            if (frame_en) nxt_state = S_VSYNC;
         end
         S_VSYNC: begin
            if (phase_cnt == VSYNC_LAST) nxt_state = S_VBP;
            else                         nxt_phase = phase_cnt + 16'd1;
         end
         S_VBP: begin
            if (phase_cnt == VBP_LAST) nxt_state = S_ACTIVE;
            else                       nxt_phase = phase_cnt + 16'd1;
         end
         S_ACTIVE: begin
            if (pix_cnt == PIX_LAST) begin
               nxt_state = S_HBLANK;
               nxt_line  = line_cnt + LINE_W'(1);
            end else begin
               nxt_pix = pix_cnt + PIX_W'(1);
            end
         end
         S_HBLANK: begin
            if (phase_cnt == HBLANK_LAST)
               nxt_state = (line_cnt == LINE_LAST) ? S_VFP : S_ACTIVE;
            else
               nxt_phase = phase_cnt + 16'd1;
         end
         S_VFP: begin
            if (phase_cnt == VFP_LAST) nxt_state = frame_en ? S_VSYNC : S_IDLE;
            else                       nxt_phase = phase_cnt + 16'd1;
         end
         default: nxt_state = S_IDLE;
      endcase
      if (nxt_state != state) begin
         nxt_phase = '0;
         nxt_pix   = '0;
      end
      // The line count must survive the ACTIVE/HBLANK alternation, so it clears once per frame.
      if (state == S_VSYNC && nxt_state == S_VBP) nxt_line = '0;
   end

   assign fifo_pixel = fifo_empty ? 16'h0000 : fifo_rd_data;

`ifdef OV5640_TX_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

   logic             pat_mode;
   logic [PIX_W-1:0] pix_idx;
   logic [15:0]      bar_pixel;

   function automatic logic [15:0] bar_color(input int bar);
      case (bar)
         0:       return 16'hFFFF;
         1:       return 16'hFFE0;
         2:       return 16'h07FF;
         3:       return 16'h07E0;
         4:       return 16'hF81F;
         5:       return 16'hF800;
         6:       return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n)       pat_mode <= 1'b0;
      else if (frame_begin) pat_mode <= pattern_sel;
   end

   // Index of the pixel whose high byte is loaded this edge; a line always starts at pixel 0.
   assign pix_idx     = (state == S_ACTIVE) ? ((pix_cnt + PIX_W'(1)) >> 1) : '0;
   assign bar_pixel   = bar_color(int'(pix_idx) / BAR_W);
   assign use_pattern = pat_mode;
   assign src_pixel   = use_pattern ? bar_pixel : fifo_pixel;
`else
   assign use_pattern = 1'b0;
   assign src_pixel   = fifo_pixel;
`endif

   always_comb begin
      load_h = (state == S_VBP    && phase_cnt == VBP_LAST)
            || (state == S_HBLANK && phase_cnt == HBLANK_LAST && line_cnt != LINE_LAST)
            || (state == S_ACTIVE && pix_cnt != PIX_LAST && pix_cnt[0]);
      load_l        = (state == S_ACTIVE) && !pix_cnt[0];
      frame_begin   = (nxt_state == S_VSYNC) && (state != S_VSYNC);
      vsync_nxt     = (nxt_state == S_VSYNC);
      href_nxt      = load_h | load_l;
      fifo_rd_en    = load_h && !fifo_empty && !use_pattern;
      underflow_nxt = underflow | (load_h && fifo_empty && !use_pattern);
      pixel_nxt     = load_h ? src_pixel : pixel_reg;
      data_nxt      = 8'h00;
      if (load_h)      data_nxt = src_pixel[15:8];
      else if (load_l) data_nxt = pixel_reg[7:0];
   end

   always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ov5640_vsync <= 1'b0;
         ov5640_href  <= 1'b0;
         ov5640_data  <= 8'h00;
         frame_start  <= 1'b0;
         underflow    <= 1'b0;
         pixel_reg    <= 16'h0000;
      end else begin
         ov5640_vsync <= vsync_nxt;
         ov5640_href  <= href_nxt;
         ov5640_data  <= data_nxt;
         frame_start  <= frame_begin;
         underflow    <= underflow_nxt;
         pixel_reg    <= pixel_nxt;
      end
   end

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Bench for ov5640_dvp_tx: frame-position model plus a FWFT FIFO stub; pattern instance only
// when OV5640_TX_PATTERN_EN is defined.
module tb_ov5640_dvp_tx;

   localparam int H = 4, HB = 3, V = 2, VS = 2, VB = 3, VF = 2;
   localparam int LINE_LEN  = 2 * H + HB;
   localparam int BODY0     = VS + VB;
   localparam int FRAME_LEN = BODY0 + V * LINE_LEN + VF;

   logic        ov5640_pclk = 1'b0;
   logic        sys_rst_n   = 1'b0;
   logic        frame_en    = 1'b0;
   logic        pat_en      = 1'b0;
   logic [15:0] fifo_rd_data;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        ov5640_vsync;
   logic        ov5640_href;
   logic [7:0]  ov5640_data;
   logic        frame_start;
   logic        underflow;

   logic [15:0] fifo_mem [32];
   logic [5:0]  fifo_cnt = '0;
   logic [5:0]  rd_ptr   = '0;
   logic        fifo_clr = 1'b0;
   int          pop_cnt  = 0;
   int          cyc      = 0;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  cap [$];
   int          fs_q [$];
   int          vs_cnt = 0;

   logic [15:0] words [16] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                               16'h1111, 16'h2222, 16'h3333, 16'h4444,
                               16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                               16'h1111, 16'h2222, 16'h3333, 16'h4444};
   logic [7:0] exp_basic [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                                  8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
   logic [7:0] exp_uf [16]    = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   assign fifo_empty   = (rd_ptr >= fifo_cnt);
   assign fifo_rd_data = fifo_mem[rd_ptr[4:0]];

   always #5 ov5640_pclk = ~ov5640_pclk;

   always @(posedge ov5640_pclk) cyc <= cyc + 1;

   always @(posedge ov5640_pclk) begin
      if (fifo_clr) begin
         rd_ptr  <= '0;
         pop_cnt <= 0;
      end else if (fifo_rd_en) begin
         rd_ptr  <= rd_ptr + 6'd1;
         pop_cnt <= pop_cnt + 1;
      end
   end

   ov5640_dvp_tx #(
      .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(V),
      .VSYNC_CYC(VS), .V_BACK_CYC(VB), .V_FRONT_CYC(VF)
   ) u_dut (
      .ov5640_pclk  (ov5640_pclk),
      .sys_rst_n    (sys_rst_n),
      .frame_en     (frame_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
`ifdef OV5640_TX_PATTERN_EN
      .pattern_sel  (1'b0),
`endif
      .fifo_rd_en   (fifo_rd_en),
      .ov5640_vsync (ov5640_vsync),
      .ov5640_href  (ov5640_href),
      .ov5640_data  (ov5640_data),
      .frame_start  (frame_start),
      .underflow    (underflow)
   );

`ifdef OV5640_TX_PATTERN_EN
   logic       p_rd_en, p_vsync, p_href, p_fs, p_uf;
   logic [7:0] p_data;
   logic [7:0] pat_cap [$];
   int         pat_pops = 0;
   logic [7:0] exp_pat [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

   ov5640_dvp_tx #(
      .H_ACTIVE(8), .H_BLANK(HB), .V_ACTIVE(V),
      .VSYNC_CYC(VS), .V_BACK_CYC(VB), .V_FRONT_CYC(VF)
   ) u_pat (
      .ov5640_pclk  (ov5640_pclk),
      .sys_rst_n    (sys_rst_n),
      .frame_en     (pat_en),
      .fifo_rd_data (16'h0000),
      .fifo_empty   (1'b1),
      .pattern_sel  (1'b1),
      .fifo_rd_en   (p_rd_en),
      .ov5640_vsync (p_vsync),
      .ov5640_href  (p_href),
      .ov5640_data  (p_data),
      .frame_start  (p_fs),
      .underflow    (p_uf)
   );
`endif

   // Model: position of the current cycle within the frame (-1 when idle) and the
   // pixel whose bytes are on the bus, drawn from the stimulus FIFO contents.
   int          m_pos = -1;
   logic [5:0]  m_ptr = '0;
   logic [15:0] m_pix = '0;
   logic        m_uf  = 1'b0;

   function automatic bit is_active(input int p);
      if (p < BODY0 || p - BODY0 >= V * LINE_LEN) return 1'b0;
      return ((p - BODY0) % LINE_LEN) < 2 * H;
   endfunction

   function automatic bit is_high(input int p);
      return is_active(p) && ((((p - BODY0) % LINE_LEN) % 2) == 0);
   endfunction

   function automatic int next_pos(input int p, input logic en);
      if (p < 0 || p == FRAME_LEN - 1) return en ? 0 : -1;
      return p + 1;
   endfunction

   always @(posedge ov5640_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_pos <= -1;
         m_uf  <= 1'b0;
         m_pix <= '0;
      end else begin
         m_pos <= next_pos(m_pos, frame_en);
         if (fifo_clr) begin
            m_ptr <= '0;
         end else if (is_high(next_pos(m_pos, frame_en))) begin
            if (m_ptr < fifo_cnt) begin
               m_pix <= fifo_mem[m_ptr[4:0]];
               m_ptr <= m_ptr + 6'd1;
            end else begin
               m_pix <= '0;
               m_uf  <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare every output against the model at the falling edge, then
   // return 1 time unit after the next rising edge so inputs can be driven.
   task automatic step();
      logic [7:0] exp_d;
      logic       exp_rd;
      @(negedge ov5640_pclk);
      if (sys_rst_n) begin
         exp_d  = !is_active(m_pos) ? 8'h00 : (is_high(m_pos) ? m_pix[15:8] : m_pix[7:0]);
         exp_rd = (m_pos >= 0) && is_high(m_pos + 1) && (m_ptr < fifo_cnt);
         check("vsync",       ov5640_vsync, (m_pos >= 0 && m_pos < VS));
         check("frame_start", frame_start,  (m_pos == 0));
         check("href",        ov5640_href,  is_active(m_pos));
         check("data",        ov5640_data,  exp_d);
         check("fifo_rd_en",  fifo_rd_en,   exp_rd);
         check("underflow",   underflow,    m_uf);
         if (ov5640_href)  cap.push_back(ov5640_data);
         if (frame_start)  fs_q.push_back(cyc);
         if (ov5640_vsync) vs_cnt++;
`ifdef OV5640_TX_PATTERN_EN
         if (p_href)  pat_cap.push_back(p_data);
         if (p_rd_en) pat_pops++;
`endif
      end
      @(posedge ov5640_pclk);
      #1;
   endtask

   task automatic fifo_load(input int n);
      for (int i = 0; i < 32; i++) fifo_mem[i] = (i < n) ? words[i % 16] : 16'h0000;
      fifo_cnt = 6'(n);
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      step();
      step();
      sys_rst_n = 1'b1;
      step();
   endtask

   task automatic check_bytes(input string name, input int base, input int n,
                              input logic [7:0] exp [16]);
      check({name, "_count"}, cap.size() - base, n);
      for (int i = 0; i < n && base + i < cap.size(); i++)
         check(name, cap[base + i], exp[i % 16]);
   endtask

   initial begin
      int base, fsb, vsb;
      for (int i = 0; i < 32; i++) fifo_mem[i] = 16'h0000;

      repeat (3) step();
      check("reset_outputs", {ov5640_vsync, ov5640_href, ov5640_data, frame_start, underflow, fifo_rd_en}, 0);
      sys_rst_n = 1'b1;
      step();

      // Basic frame: one frame_en pulse, 8 preloaded pixels.
      fifo_load(8);
      base = cap.size(); fsb = fs_q.size(); vsb = vs_cnt;
      frame_en = 1'b1; pat_en = 1'b1;
      step();
      frame_en = 1'b0; pat_en = 1'b0;
      repeat (50) step();
      check_bytes("basic_byte", base, 16, exp_basic);
      check("basic_pops", pop_cnt, 8);
      check("basic_frame_starts", fs_q.size() - fsb, 1);
      check("basic_vsync_cycles", vs_cnt - vsb, VS);
      check("basic_underflow", underflow, 0);
`ifdef OV5640_TX_PATTERN_EN
      check("pat_count", pat_cap.size(), 32);
      for (int i = 0; i < 32 && i < pat_cap.size(); i++) check("pat_byte", pat_cap[i], exp_pat[i % 16]);
      check("pat_pops", pat_pops, 0);
      check("pat_underflow", p_uf, 0);
`endif

      // Continuous mode: frame_en held, two frames back to back.
      fifo_load(16);
      base = cap.size(); fsb = fs_q.size();
      frame_en = 1'b1;
      for (int i = 0; i < 200 && fs_q.size() < fsb + 2; i++) step();
      frame_en = 1'b0;
      repeat (40) step();
      check("cont_frame_starts", fs_q.size() - fsb, 2);
      if (fs_q.size() >= fsb + 2) check("cont_spacing", fs_q[fsb + 1] - fs_q[fsb], 29);
      check_bytes("cont_byte", base, 32, exp_basic);
      check("cont_pops", pop_cnt, 16);

      // Underflow: only 3 words available.
      fifo_load(3);
      base = cap.size();
      frame_en = 1'b1;
      step();
      frame_en = 1'b0;
      repeat (40) step();
      check_bytes("uf_byte", base, 16, exp_uf);
      check("uf_pops", pop_cnt, 3);
      check("uf_flag", underflow, 1);

      // Mid-frame disable: frame_en dropped during line 0.
      do_reset();
      check("reset_clears_underflow", underflow, 0);
      fifo_load(8);
      base = cap.size(); fsb = fs_q.size(); vsb = vs_cnt;
      frame_en = 1'b1;
      for (int i = 0; i < 100 && cap.size() == base; i++) step();
      check("mid_href_seen", cap.size() > base, 1);
      frame_en = 1'b0;
      repeat (60) step();
      check_bytes("mid_byte", base, 16, exp_basic);
      check("mid_frame_starts", fs_q.size() - fsb, 1);
      check("mid_vsync_cycles", vs_cnt - vsb, VS);

      // Reset during line 1 with underflow already set, released with frame_en high.
      fifo_load(3);
      base = cap.size();
      frame_en = 1'b1;
      for (int i = 0; i < 100 && cap.size() < base + 10; i++) step();
      check("rst_line1_reached", cap.size() >= base + 10, 1);
      check("rst_pre_underflow", underflow, 1);
      sys_rst_n = 1'b0;
      #1;
      check("rst_async_outputs", {ov5640_vsync, ov5640_href, ov5640_data, frame_start, underflow, fifo_rd_en}, 0);
      step();
      step();
      sys_rst_n = 1'b1;
      check("rst_underflow_cleared", underflow, 0);
      fsb = fs_q.size();
      step();
      step();
      check("rst_restart_vsync", ov5640_vsync, 1);
      check("rst_restart_frame_start", fs_q.size() - fsb, 1);
      frame_en = 1'b0;
      repeat (40) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
